// File: rtl/l1i_pkg.sv
// Shared L1 instruction-cache types and geometry constants.
// The line store is banked into 32-bit slices so each bank maps onto one block RAM.
package l1i_pkg;

  localparam int L1I_OFFSET_BITS = 5;
  localparam int L1I_INDEX_BITS  = 8;
  localparam int L1I_LINE_BITS   = 256;
  localparam int L1I_BANK_BITS   = 32;

  typedef logic [0:L1I_LINE_BITS-1]  l1i_line_t;
  typedef logic [L1I_INDEX_BITS-1:0] l1i_index_t;

endpackage

// File: rtl/l1i_mem_bank.sv
// One 32-bit slice of the L1I line store: single-port, write-first RAM with a registered read.
// The output register is the only state touched by reset; contents survive it.
module l1i_mem_bank #(
  parameter int ADDR_WIDTH = 8,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [0:WORD_WIDTH-1] dina,
  output logic [0:WORD_WIDTH-1] douta
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [0:WORD_WIDTH-1] mem [DEPTH] = '{default: '0};

  // Writes are dropped while reset is held so a fill racing a flush cannot land.
  always_ff @(posedge clka) begin
    if (rsta && wea) begin
      mem[addra] <= dina;
    end
  end

  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      douta <= '0;
    end else if (wea) begin
      douta <= dina;
    end else begin
      douta <= mem[addra];
    end
  end

endmodule

// File: rtl/l1i_memory.sv
// L1I cacheline store: DATA_WIDTH/32 parallel banks sharing address, enable and reset.
// Read latency is one cycle; writes return the written line on douta (write-first).
module l1i_memory
  import l1i_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 256
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [0:DATA_WIDTH-1] dina,
  output logic [0:DATA_WIDTH-1] douta
);

  localparam int NUM_BANKS = DATA_WIDTH / L1I_BANK_BITS;

  if ((DATA_WIDTH % L1I_BANK_BITS) != 0 || DATA_WIDTH == 0) begin : g_bad_width
    $error("l1i_memory: DATA_WIDTH must be a non-zero multiple of 32");
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    l1i_mem_bank #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .WORD_WIDTH (L1I_BANK_BITS)
    ) u_bank (
      .clka  (clka),
      .rsta  (rsta),
      .wea   (wea),
      .addra (addra),
      .dina  (dina[b*L1I_BANK_BITS +: L1I_BANK_BITS]),
      .douta (douta[b*L1I_BANK_BITS +: L1I_BANK_BITS])
    );
  end

endmodule

// File: tb/tb_l1i_memory.sv
// Self-checking bench for l1i_memory: directed cases followed by randomized traffic
// compared against an array-based model of the line store.
module tb_l1i_memory;
  import l1i_pkg::*;

  logic       clka = 1'b0;
  logic       rsta = 1'b0;
  logic       wea = 1'b0;
  l1i_index_t addra = '0;
  l1i_line_t  dina = '0;
  l1i_line_t  douta;

  l1i_line_t  model [256];
  l1i_line_t  exp_out;
  int         checks = 0;
  int         errors = 0;

  localparam l1i_line_t PAT_A = 256'hDEADBEEF_01234567_89ABCDEF_CAFEF00D_11111111_22222222_33333333_44444444;
  localparam l1i_line_t PAT_B = 256'hB0B0B0B0_0000000B_F00DFACE_12345678_9ABCDEF0_0F0F0F0F_F0F0F0F0_ABCDABCD;
  localparam l1i_line_t PAT_C = 256'hC0C0C0C0_CCCCCCCC_00000001_80000000_7FFFFFFF_FFFFFFFE_13579BDF_2468ACE0;
  localparam l1i_line_t PAT_D = 256'hD00DD00D_55555555_AAAAAAAA_00FF00FF_FF00FF00_DDDDDDDD_01010101_10101010;
  localparam l1i_line_t PAT_E = 256'hEEEEEEEE_E0E0E0E0_0E0E0E0E_12121212_34343434_56565656_78787878_9A9A9A9A;

  l1i_memory #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (256)
  ) dut (
    .clka  (clka),
    .rsta  (rsta),
    .wea   (wea),
    .addra (addra),
    .dina  (dina),
    .douta (douta)
  );

  always #5 clka = ~clka;

  function automatic l1i_line_t randLine();
    l1i_line_t v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input l1i_line_t observed, input l1i_line_t expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one access, let the edge happen, then update the model: the store
  // only changes on a write with reset released; output follows write-first rules.
  task automatic applyStimulus(input logic we, input l1i_index_t addr, input l1i_line_t data);
    wea   = we;
    addra = addr;
    dina  = data;
    @(posedge clka);
    #1;
    if (!rsta) begin
      exp_out = '0;
    end else if (we) begin
      model[addr] = data;
      exp_out     = data;
    end else begin
      exp_out = model[addr];
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model[i] = '0;
    exp_out = '0;

    #1;
    checkOutput("reset_initial", douta, '0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, '0);
      checkOutput("reset_hold", douta, exp_out);
    end
    rsta = 1'b1;
    applyStimulus(1'b0, 8'h00, '0);
    checkOutput("read_after_reset", douta, '0);

    applyStimulus(1'b1, 8'h05, PAT_A);
    checkOutput("write_first_a", douta, PAT_A);
    applyStimulus(1'b0, 8'h05, '0);
    checkOutput("read_a", douta, PAT_A);

    applyStimulus(1'b1, 8'h10, PAT_B);
    checkOutput("write_first_b", douta, PAT_B);

    applyStimulus(1'b1, 8'hFF, PAT_C);
    checkOutput("alt_write_c", douta, PAT_C);
    applyStimulus(1'b0, 8'h05, '0);
    checkOutput("alt_read_a", douta, PAT_A);
    applyStimulus(1'b1, 8'h00, PAT_D);
    checkOutput("alt_write_d", douta, PAT_D);
    applyStimulus(1'b0, 8'hFF, '0);
    checkOutput("alt_read_c", douta, PAT_C);
    applyStimulus(1'b0, 8'h00, '0);
    checkOutput("alt_read_d", douta, PAT_D);

    applyStimulus(1'b0, 8'h05, '0);
    checkOutput("pre_async_a", douta, PAT_A);
    #2 rsta = 1'b0;
    #1;
    checkOutput("async_reset_clear", douta, '0);
    applyStimulus(1'b1, 8'h20, PAT_E);
    checkOutput("write_in_reset_out", douta, exp_out);
    rsta = 1'b1;
    applyStimulus(1'b0, 8'h20, '0);
    checkOutput("write_in_reset_dropped", douta, '0);
    applyStimulus(1'b0, 8'h05, '0);
    checkOutput("retained_after_reset", douta, PAT_A);
    applyStimulus(1'b0, 8'h10, '0);
    checkOutput("retained_b", douta, PAT_B);

    // Randomized traffic with occasional asynchronous reset pulses.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 24) == 0) begin
        #2 rsta = 1'b0;
        #1;
        checkOutput("rand_async_reset", douta, '0);
        applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), randLine());
        checkOutput("rand_in_reset", douta, exp_out);
        rsta = 1'b1;
      end else begin
        applyStimulus(1'($urandom_range(0, 2) == 0), 8'($urandom_range(0, 255)), randLine());
        checkOutput("rand_access", douta, exp_out);
      end
    end

    // Sweep every index so any stored corruption is observed.
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b0, 8'(i), '0);
      checkOutput("final_sweep", douta, exp_out);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
